// File: rtl/nandy_control_decoder_if.sv
// ---------------------------------------------------------------------------
// nandy_control_decoder_if
//   Bundle between the instruction register side (master) and the Nandy
//   control decoder (slave).
//   master drives : inst[7:0], cycle, carry
//   slave drives  : M S J LJ CLI LJR MW MC RD WR Y RS[1:0] WA ISP WC
//                   ALU[3:0] nSIG[7:0]
// ---------------------------------------------------------------------------
interface nandy_control_decoder_if;
  logic [7:0] inst;
  logic       cycle;
  logic       carry;

  logic       M;
  logic       S;
  logic       J;
  logic       LJ;
  logic       CLI;
  logic       LJR;
  logic       MW;
  logic       MC;
  logic       RD;
  logic       WR;
  logic       Y;
  logic [1:0] RS;
  logic       WA;
  logic       ISP;
  logic       WC;
  logic [3:0] ALU;
  logic [7:0] nSIG;

  modport master (
    output inst, cycle, carry,
    input  M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, RS, WA, ISP, WC, ALU, nSIG
  );

  modport slave (
    input  inst, cycle, carry,
    output M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, RS, WA, ISP, WC, ALU, nSIG
  );
endinterface

// File: rtl/nandy_control_decoder.sv
// ---------------------------------------------------------------------------
// nandy_control_decoder
//   Instruction decoder for the Nandy 8-bit CPU. Turns the opcode byte, the
//   two-phase cycle flag and the carry flag into every datapath / memory /
//   IO control strobe.
//
//   Ports:
//     clk  - system clock, output registers update on the rising edge
//     rst  - synchronous active-high reset (outputs 0, nSIG = 8'hFF)
//     bus  - nandy_control_decoder_if.slave
//            in : inst[7:0], cycle, carry
//            out: M S J LJ CLI LJR MW MC RD WR Y RS[1:0] WA ISP WC
//                 ALU[3:0] nSIG[7:0] (active-low one-hot)
//
//   Build option:
//     NANDY_CTRL_COMB_OUT_EN - when defined the output registers are bypassed
//     and every output is the combinational decode of the current inputs;
//     clk and rst are then unused. Default: registered, 1-cycle latency.
// ---------------------------------------------------------------------------
module nandy_control_decoder (
  input  logic                          clk,
  input  logic                          rst,
  nandy_control_decoder_if.slave        bus
);

  typedef struct packed {
    logic       m;
    logic       s;
    logic       j;
    logic       lj;
    logic       cli;
    logic       ljr;
    logic       mw;
    logic       mc;
    logic       rd;
    logic       wr;
    logic       y;
    logic [1:0] rs;
    logic       wa;
    logic       isp;
    logic       wc;
    logic [3:0] alu;
    logic [7:0] nsig;
  } ctl_t;

  logic [7:0] inst;
  logic       cyc;
  logic       cy;

  assign inst = bus.inst;
  assign cyc  = bus.cycle;
  assign cy   = bus.carry;

  // Shared helper terms: every strobe below is derived from this one decode
  // so related outputs (MW/M, CLI/LJR/LJ, RD/WR) can never disagree.
  logic z_op;   // opcode class 000xxxxx
  logic a_op;   // ALU-result-to-accumulator class

  ctl_t ctl_d;
  ctl_t ctl_o;

  always_comb begin
    z_op = ~inst[7] & ~inst[6] & ~inst[5];
    a_op = (inst[6] & ~inst[7]) | (cyc & inst[6] & ~inst[5]);

    ctl_d       = '0;
    ctl_d.m     = inst[7] & ~inst[6] & cyc;
    ctl_d.s     = inst[4];
    ctl_d.j     = inst[7] & inst[6] & inst[5] & cyc & ~(cy & inst[4]);
    ctl_d.lj    = z_op & inst[4] & ~inst[3];
    ctl_d.cli   = ctl_d.lj & inst[1];
    ctl_d.ljr   = ctl_d.lj & inst[2];
    ctl_d.mw    = ctl_d.m & inst[5];
    ctl_d.mc    = inst[7] & ~cyc;
    ctl_d.rd    = z_op & ~inst[4] & inst[2];
    ctl_d.wr    = z_op & ~inst[4] & inst[3];
    ctl_d.y     = inst[5];
    ctl_d.rs    = inst[1:0];
    ctl_d.wa    = (ctl_d.m & ~inst[5]) | (a_op & ~(inst[4] & ~inst[3]));
    ctl_d.isp   = ~inst[7] & ~inst[6] & inst[5];
    ctl_d.wc    = (a_op | ctl_d.isp) & inst[4];
    ctl_d.alu   = inst[6] ? inst[3:0] : {~inst[7], 3'b000};

    // Signal lines: opcodes 00011nnn pull line nnn low, everything else idles.
    ctl_d.nsig  = '1;
    if (inst[7:3] == 5'b00011) begin
      ctl_d.nsig = ~(8'd1 << inst[2:0]);
    end
  end

`ifdef NANDY_CTRL_COMB_OUT_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign ctl_o = ctl_d;
`else
  ctl_t ctl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q      <= '0;
      ctl_q.nsig <= '1;
    end else begin
      ctl_q      <= ctl_d;
    end
  end

  assign ctl_o = ctl_q;
`endif

  assign bus.M    = ctl_o.m;
  assign bus.S    = ctl_o.s;
  assign bus.J    = ctl_o.j;
  assign bus.LJ   = ctl_o.lj;
  assign bus.CLI  = ctl_o.cli;
  assign bus.LJR  = ctl_o.ljr;
  assign bus.MW   = ctl_o.mw;
  assign bus.MC   = ctl_o.mc;
  assign bus.RD   = ctl_o.rd;
  assign bus.WR   = ctl_o.wr;
  assign bus.Y    = ctl_o.y;
  assign bus.RS   = ctl_o.rs;
  assign bus.WA   = ctl_o.wa;
  assign bus.ISP  = ctl_o.isp;
  assign bus.WC   = ctl_o.wc;
  assign bus.ALU  = ctl_o.alu;
  assign bus.nSIG = ctl_o.nsig;

endmodule

// File: tb/tb_nandy_control_decoder.sv
// ---------------------------------------------------------------------------
// tb_nandy_control_decoder
//   Self-checking bench for nandy_control_decoder. Directed opcode checks,
//   an exhaustive sweep of {inst, cycle, carry}, a mid-run reset, and a
//   randomized run, all compared against a reference model written from the
//   opcode-class rules of the ISA.
//   Output vector packing (low to high): nSIG[7:0] ALU[3:0] WC ISP WA RS[1:0]
//   Y WR RD MC MW LJR CLI LJ J S M.
// ---------------------------------------------------------------------------
module tb_nandy_control_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  nandy_control_decoder_if bus ();

  nandy_control_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] RESET_VEC = 32'h0000_00FF;

  function automatic logic [31:0] observed();
    return {4'h0, bus.M, bus.S, bus.J, bus.LJ, bus.CLI, bus.LJR, bus.MW, bus.MC,
            bus.RD, bus.WR, bus.Y, bus.RS, bus.WA, bus.ISP, bus.WC, bus.ALU, bus.nSIG};
  endfunction

  // Reference model: opcode classes expressed as ranges / field compares.
  function automatic logic [31:0] model(input logic [7:0] in, input logic cyc, input logic cy);
    bit z, a, m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, wa, isp, wc;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [7:0] nsig;
    z    = (in < 8'h20);
    a    = (in[7:6] == 2'b01) || (cyc && in[6:5] == 2'b10);
    m    = (in[7:6] == 2'b10) && cyc;
    s    = in[4];
    j    = (in[7:5] == 3'b111) && cyc && !(cy && in[4]);
    lj   = z && (in[4:3] == 2'b10);
    cli  = lj && in[1];
    ljr  = lj && in[2];
    mw   = m && in[5];
    mc   = in[7] && !cyc;
    rd   = z && !in[4] && in[2];
    wr   = z && !in[4] && in[3];
    y    = in[5];
    rs   = in[1:0];
    wa   = (m && !in[5]) || (a && in[4:3] != 2'b10);
    isp  = (in[7:5] == 3'b001);
    wc   = (a || isp) && in[4];
    alu  = in[6] ? in[3:0] : (in[7] ? 4'd0 : 4'd8);
    nsig = (in[7:3] == 5'b00011) ? (8'hFF ^ (8'd1 << in[2:0])) : 8'hFF;
    return {4'h0, m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, rs, wa, isp, wc, alu, nsig};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [7:0] in, input logic cyc, input logic cy);
    @(negedge clk);
    bus.inst  = in;
    bus.cycle = cyc;
    bus.carry = cy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  ri;
    logic        rc, rk;
    logic [31:0] exp_rst;

    bus.inst  = 8'hFF;
    bus.cycle = 1'b1;
    bus.carry = 1'b0;
    rst       = 1'b1;

    // Reset held for two edges with a "busy" opcode on the inputs.
    apply(8'hFF, 1'b1, 1'b0);
    apply(8'hFF, 1'b1, 1'b0);
`ifdef NANDY_CTRL_COMB_OUT_EN
    exp_rst = model(8'hFF, 1'b1, 1'b0);
`else
    exp_rst = RESET_VEC;
`endif
    check("reset_vec", observed(), exp_rst);
    rst = 1'b0;

    apply(8'h1B, 1'b0, 1'b0);
    check("1B_nSIG", {24'h0, bus.nSIG}, 32'hF7);
    check("1B_S_RS_ALU", {bus.S, bus.RS, bus.ALU}, {1'b1, 2'd3, 4'h8});
    check("1B_LJ_WA_WC", {bus.LJ, bus.WA, bus.WC}, 3'b000);

    apply(8'h16, 1'b0, 1'b0);
    check("16_LJ_CLI_LJR", {bus.LJ, bus.CLI, bus.LJR}, 3'b111);
    check("16_S_RS_RD", {bus.S, bus.RS, bus.RD}, {1'b1, 2'd2, 1'b0});
    check("16_ALU_nSIG", {bus.ALU, bus.nSIG}, {4'h8, 8'hFF});

    apply(8'hF0, 1'b1, 1'b1);
    check("F0_carry1_J", bus.J, 1'b0);
    apply(8'hF0, 1'b1, 1'b0);
    check("F0_carry0_J", bus.J, 1'b1);
    check("F0_Y_S_ALU_MC_WA", {bus.Y, bus.S, bus.ALU, bus.MC, bus.WA}, {1'b1, 1'b1, 4'h0, 1'b0, 1'b0});

    apply(8'hA0, 1'b1, 1'b0);
    check("A0_c1_M_MW_MC", {bus.M, bus.MW, bus.MC}, 3'b110);
    check("A0_c1_Y_ALU", {bus.Y, bus.ALU}, {1'b1, 4'h0});
    apply(8'hA0, 1'b0, 1'b0);
    check("A0_c0_M_MW_MC", {bus.M, bus.MW, bus.MC}, 3'b001);

    apply(8'h5C, 1'b0, 1'b0);
    check("5C_WA_WC_ALU", {bus.WA, bus.WC, bus.ALU}, {1'b1, 1'b1, 4'hC});
    check("5C_S_Y_RS", {bus.S, bus.Y, bus.RS}, {1'b1, 1'b0, 2'd0});

    apply(8'h0C, 1'b0, 1'b0);
    check("0C_RD_WR_ALU", {bus.RD, bus.WR, bus.ALU}, {1'b1, 1'b1, 4'h8});

    // Exhaustive sweep of all 1024 input combinations.
    for (int unsigned k = 0; k < 1024; k++) begin
      ri = k[9:2];
      rc = k[1];
      rk = k[0];
      apply(ri, rc, rk);
      check($sformatf("sweep_%02h_c%0d_k%0d", ri, rc, rk), observed(), model(ri, rc, rk));
      check("sweep_MW_implies_M", {31'h0, bus.MW & ~bus.M}, 32'h0);
    end

    // Reset asserted mid-operation, then released.
    apply(8'hE7, 1'b1, 1'b0);
    check("pre_midrst", observed(), model(8'hE7, 1'b1, 1'b0));
    rst = 1'b1;
    apply(8'h5F, 1'b1, 1'b1);
`ifdef NANDY_CTRL_COMB_OUT_EN
    exp_rst = model(8'h5F, 1'b1, 1'b1);
`else
    exp_rst = RESET_VEC;
`endif
    check("midrst_vec", observed(), exp_rst);
    rst = 1'b0;
    apply(8'h1D, 1'b0, 1'b0);
    check("post_midrst", observed(), model(8'h1D, 1'b0, 1'b0));

    // Randomized run.
    for (int unsigned n = 0; n < 600; n++) begin
      ri = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      rk = 1'($urandom_range(1));
      apply(ri, rc, rk);
      check($sformatf("rand_%02h_c%0d_k%0d", ri, rc, rk), observed(), model(ri, rc, rk));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
